seq_detect_param: RTL

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_detect_param.sv | 73 +++++++
 1 files changed

// File: rtl/seq_detect_param.sv
// Serial pattern detector with a loadable pattern, an optional overlap mode,
// a registered match pulse and a saturating match counter.
module seq_detect_param #(
  parameter int               PAT_W   = 5,
  parameter logic [PAT_W-1:0] DEF_PAT = 5'b10101,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             clr_cnt,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int                FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [PAT_W-1:0]  pat_q;
  logic [PAT_W-1:0]  hist_q;
  logic [FILL_W-1:0] fill_q;
  logic              z_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [PAT_W-1:0]  hist_d;
  logic [FILL_W-1:0] fill_d;
  logic              match_d;
  logic [CNT_W-1:0]  cnt_d;

  // The fill requirement keeps an all-zero history from matching a zero pattern.
  always_comb begin
    hist_d  = {hist_q[PAT_W-2:0], x};
    fill_d  = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
    match_d = en && !load && (hist_d == pat_q) && (fill_d == FILL_FULL);
    cnt_d   = cnt_q;
    if (clr_cnt) begin
      cnt_d = match_d ? CNT_W'(1) : '0;
    end else if (match_d && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= DEF_PAT;
      hist_q <= '0;
      fill_q <= '0;
      z_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      z_q   <= match_d;
      cnt_q <= cnt_d;
      if (load) begin
        pat_q  <= pat_in;
        hist_q <= '0;
        fill_q <= '0;
      end else if (en) begin
        hist_q <= hist_d;
        // Non-overlapping mode restarts the fill so the next match needs fresh bits.
        fill_q <= (match_d && !OVERLAP) ? '0 : fill_d;
      end
    end
  end

  assign z         = z_q;
  assign match_cnt = cnt_q;

endmodule
